clock_display_mux: RTL

Time-multiplexed six-digit seven-segment driver for the clock/chronometer datapath. It consumes the binary seconds, minutes and hours words plus the clock/chronometer mode flag, converts each to two BCD digits, and scans them onto a common-anode display. Inputs are captured once per display frame so a digit set is never torn mid-scan. It sits directly downstream of the clock block and drives the board's display pins.

---
 rtl/clock_display_mux.sv | 106 ++++++++++
 1 files changed

// File: rtl/clock_display_mux.sv
// clock_display_mux: six-digit multiplexed 7-seg driver; CLOCK_DISP_LZB_EN enables hour-tens blanking
module clock_display_mux #(
    parameter int SCAN_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic [4:0] hour,
    input  logic       mode,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame
);
    localparam int PW = $clog2(SCAN_DIV);

    logic [PW-1:0] p;
    logic [2:0]    idx;
    logic [5:0]    sh_sec, sh_min;
    logic [4:0]    sh_hour;
    logic          sh_mode;
    logic          wrap, snap, bad_v, blank, dp_n;
    logic [5:0]    val, rem, an_n;
    logic [3:0]    tens, dig;
    logic [6:0]    seg_n;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    assign wrap = p == PW'(SCAN_DIV - 1);
    assign snap = wrap && idx == 3'd5;

`ifdef CLOCK_DISP_LZB_EN
    assign blank = idx == 3'd5 && sh_hour < 5'd10;
`else
    assign blank = 1'b0;
`endif

    // prescaler, digit index and per-frame input snapshot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p       <= '0;
            idx     <= '0;
            sh_sec  <= '0;
            sh_min  <= '0;
            sh_hour <= '0;
            sh_mode <= 1'b0;
            frame   <= 1'b0;
        end else begin
            p     <= wrap ? '0 : p + 1'b1;
            frame <= snap;
            if (wrap)
                idx <= idx == 3'd5 ? 3'd0 : idx + 3'd1;
            if (snap) begin
                sh_sec  <= sec;
                sh_min  <= min;
                sh_hour <= hour;
                sh_mode <= mode;
            end
        end
    end

    // select the current field and split it into BCD by repeated subtraction
    always_comb begin
        val   = idx < 3'd2 ? sh_sec : idx < 3'd4 ? sh_min : {1'b0, sh_hour};
        bad_v = idx < 3'd4 ? val > 6'd59 : val > 6'd23;
        rem   = val;
        tens  = 4'd0;
        for (int i = 0; i < 6; i++)
            if (rem >= 6'd10) begin
                rem  = rem - 6'd10;
                tens = tens + 4'd1;
            end
        dig   = idx[0] ? tens : rem[3:0];
        seg_n = blank ? 7'b1111111 : bad_v ? 7'b0111111 : seg7(dig);
        an_n  = idx < 3'd6 ? ~(6'd1 << idx) : 6'b111111;
        dp_n  = !(sh_mode && (idx == 3'd2 || idx == 3'd4));
    end

    // register display pins one cycle behind the scan state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an  <= 6'b111111;
            seg <= 7'b1111111;
            dp  <= 1'b1;
        end else begin
            an  <= an_n;
            seg <= seg_n;
            dp  <= dp_n;
        end
    end
endmodule
